fifo_mac_reader: RTL and testbench

- Consumer side of the 4-entry operand FIFO: drives the FIFO read enable, captures its registered data output and multiply-accumulates operand pairs.
- Each vector pass reads VEC_LEN (A, B) pairs from the FIFO in strict order A0, B0, A1, B1, ….
- The block accumulates sum(Ai*Bi) and presents the result on a valid/ready output handshake.
- Runs on the FIFO read-side clock; the FIFO's clk_out is tied to this block's clk.

---
 rtl/fifo_mac_reader_if.sv | 29 ++
 rtl/fifo_mac_reader.sv | 104 ++++++++++
 tb/tb_fifo_mac_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mac_reader_if.sv
// Handshake bundle between fifo_mac_reader, the operand FIFO read port and the result consumer.
// DATA_WIDTH defaults to the `DATA_WIDTH macro (8) when that macro is not supplied.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fifo_mac_reader_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
);
  logic                  start;
  logic                  busy;
  logic                  n_empty;
  logic                  RE;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output start, n_empty, fifo_dout, out_ready,
    input  busy, RE, acc_out, out_valid
  );

  modport slave (
    input  start, n_empty, fifo_dout, out_ready,
    output busy, RE, acc_out, out_valid
  );
endinterface

// File: rtl/fifo_mac_reader.sv
// FIFO consumer that pops (A,B) operand pairs and multiply-accumulates them into a dot product.
// Optional macro SIGNED_MAC_EN selects two's-complement operands and a signed accumulator.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_mac_reader #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int VEC_LEN    = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_mac_reader_if.slave bus
);
  localparam int CW = (VEC_LEN < 2) ? 1 : $clog2(VEC_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    CAP_A = 3'd2,
    REQ_B = 3'd3,
    CAP_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  vld;
  logic                  bsy;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic                  last;

`ifdef SIGNED_MAC_EN
  // Operands are sign-extended to the product width so the low half is the exact signed product.
  assign prod     = $signed({{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q}) *
                    $signed({{DATA_WIDTH{bus.fifo_dout[DATA_WIDTH-1]}}, bus.fifo_dout});
  assign prod_ext = ACC_WIDTH'($signed(prod));
`else
  assign prod     = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, bus.fifo_dout};
  assign prod_ext = ACC_WIDTH'(prod);
`endif

  assign last = (cnt == CW'(VEC_LEN-1));

  // Pop only when a word is present; REQ states last at least one cycle between pops.
  assign bus.RE        = bus.n_empty && ((state == REQ_A) || (state == REQ_B));
  assign bus.acc_out   = acc;
  assign bus.out_valid = vld;
  assign bus.busy      = bsy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      acc   <= '0;
      vld   <= 1'b0;
      bsy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= REQ_A;
            acc   <= '0;
            cnt   <= '0;
            bsy   <= 1'b1;
          end
        end
        REQ_A: if (bus.n_empty) state <= CAP_A;
        CAP_A: begin
          a_q   <= bus.fifo_dout;
          state <= REQ_B;
        end
        REQ_B: if (bus.n_empty) state <= CAP_B;
        CAP_B: begin
          acc <= acc + prod_ext;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            vld   <= 1'b1;
          end else begin
            state <= REQ_A;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            vld   <= 1'b0;
            bsy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          vld   <= 1'b0;
          bsy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_mac_reader.sv
// Scoreboard bench for fifo_mac_reader: behavioural FIFO, dot-product model and a decoupled output monitor.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_fifo_mac_reader;
  localparam int DW = `DATA_WIDTH;
  localparam int VL = 4;
  localparam int AW = 2*DW+4;

  logic clk;
  logic rst_n;

  fifo_mac_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus();

  fifo_mac_reader #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] fq[$];
  logic [AW-1:0] exp_q[$];
  longint mdl = 0;
  bit   hold = 0;
  int   main_re = 0;
  int   mon_outs = 0;
  logic re_s;
  bit   m_prev = 0;
  int   m_rc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic upd();
    bus.n_empty = (fq.size() > 0) && !hold;
  endtask

  // One clock: RE sampled mid-cycle, FIFO Dout updated just after the edge that popped it.
  task automatic tick();
    @(negedge clk);
    re_s = bus.RE;
    @(posedge clk);
    #1;
    if (re_s) begin
      main_re++;
      if (fq.size() > 0) bus.fifo_dout = fq.pop_front();
    end
    upd();
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    fq.push_back(a);
    fq.push_back(b);
`ifdef SIGNED_MAC_EN
    mdl += longint'($signed(a)) * longint'($signed(b));
`else
    mdl += longint'(a) * longint'(b);
`endif
  endtask

  task automatic start_pass();
    exp_q.push_back(mdl[AW-1:0]);
    mdl = 0;
    upd();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic push_basic();
    push_pair(8'd1, 8'd5);
    push_pair(8'd2, 8'd6);
    push_pair(8'd3, 8'd7);
    push_pair(8'd4, 8'd8);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 300 && !bus.out_valid; i++) tick();
    chk(nm, 32'(bus.out_valid), 1);
  endtask

  task automatic wait_re(input int n);
    for (int i = 0; i < 300 && main_re < n; i++) tick();
    chk("re_wait", main_re, n);
  endtask

  // Monitor: RE legality every cycle, result and pop count on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_prev = 0;
        m_rc   = 0;
      end else begin
        if (bus.RE) begin
          chk("re_rule", 32'(bus.n_empty && !m_prev), 1);
          m_rc++;
        end
        m_prev = bus.RE;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none", bus.acc_out);
          end else begin
            chk("acc_out", 32'(bus.acc_out), 32'(exp_q.pop_front()));
          end
          chk("re_count", m_rc, 2*VL);
          m_rc = 0;
          mon_outs++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int target;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    bus.n_empty   = 1'b0;
    bus.fifo_dout = '0;
    rst_n         = 1'b0;
    #12;
    chk("rst_re",    32'(bus.RE), 0);
    chk("rst_acc",   32'(bus.acc_out), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd();

    // basic pass
    r0 = main_re;
    push_basic();
    start_pass();
    chk("basic_busy", 32'(bus.busy), 1);
    wait_valid("basic_valid");
    chk("basic_acc", 32'(bus.acc_out), 70);
    chk("basic_busy_dn", 32'(bus.busy), 1);
    tick();
    chk("basic_valid_off", 32'(bus.out_valid), 0);
    chk("basic_idle", 32'(bus.busy), 0);
    chk("basic_re_total", main_re - r0, 8);

    // FIFO empty for 6 cycles right after A1 is popped
    r0 = main_re;
    push_basic();
    start_pass();
    wait_re(r0 + 3);
    hold = 1; upd();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_re", 32'(re_s), 0);
      chk("stall_busy", 32'(bus.busy), 1);
    end
    hold = 0; upd();
    wait_valid("stall_valid");
    chk("stall_acc", 32'(bus.acc_out), 70);
    tick();

    // back-pressure
    bus.out_ready = 1'b0;
    push_basic();
    start_pass();
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", 32'(bus.out_valid), 1);
      chk("bp_acc_hold", 32'(bus.acc_out), 70);
      chk("bp_no_re", 32'(re_s), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_valid_off", 32'(bus.out_valid), 0);
    chk("bp_idle", 32'(bus.busy), 0);

    // start ignored in REQ_B, in DONE and on the handshake cycle
    r0 = main_re;
    push_basic();
    start_pass();
    wait_re(r0 + 1);
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.out_ready = 1'b0;
    wait_valid("ign_valid");
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("ign_done_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("ign_idle", 32'(bus.busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign_no_re", 32'(re_s), 0);
      chk("ign_no_busy", 32'(bus.busy), 0);
    end
    chk("ign_re_total", main_re - r0, 8);
    chk("ign_acc_kept", 32'(bus.acc_out), 70);

    // reset mid-pass after two pairs
    r0 = main_re;
    push_basic();
    start_pass();
    wait_re(r0 + 4);
    tick();
    chk("mid_partial", 32'(bus.acc_out), 17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_re",    32'(bus.RE), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_acc",   32'(bus.acc_out), 0);
    chk("mid_rst_busy",  32'(bus.busy), 0);
    fq.delete();
    exp_q.delete();
    mdl = 0;
    upd();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < VL; i++) push_pair(8'hFF, 8'hFF);
    start_pass();
    wait_valid("max_valid");
`ifdef SIGNED_MAC_EN
    chk("max_acc", 32'(bus.acc_out), 4);
`else
    chk("max_acc", 32'(bus.acc_out), 'h3F804);
`endif
    tick();

    // signedness
    for (int i = 0; i < VL; i++) push_pair(8'hFF, 8'h02);
    start_pass();
    wait_valid("sgn_valid");
`ifdef SIGNED_MAC_EN
    chk("sgn_acc", 32'(bus.acc_out), 'hFFFF8);
`else
    chk("sgn_acc", 32'(bus.acc_out), 'h007F8);
`endif
    tick();

    // random data, random FIFO stalls, random back-pressure
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < VL; i++)
        push_pair(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
      target = mon_outs + 1;
      start_pass();
      for (int i = 0; i < 600 && mon_outs != target; i++) begin
        hold = ($urandom_range(0, 2) == 0);
        bus.out_ready = ($urandom_range(0, 1) == 1);
        upd();
        tick();
      end
      chk("rand_done", mon_outs, target);
      hold = 0;
      bus.out_ready = 1'b1;
      upd();
      tick();
      chk("rand_idle", 32'(bus.busy), 0);
    end

    chk("exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
